// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard
// Hazard and forwarding unit for the 5-stage core. It tracks in-flight
// register writes in the STAGES stages after ID and produces:
//   - per-operand forwarding selects (0 = regfile, k = result of stage k),
//   - a one-cycle load-use stall,
//   - a saturating count of stall cycles.
// Optional feature: define HAZARD_R0_HARDWIRED_EN to make register 0 a
// hardwired zero that never matches. Without it, R0 is tracked like any
// other register.
module pipe_hazard_scoreboard #(
    parameter int ADDR_W = 3,
    parameter int STAGES = 3,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_src_a,
    input  logic              id_src_a_used,
    input  logic [ADDR_W-1:0] id_src_b,
    input  logic              id_src_b_used,
    input  logic [ADDR_W-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic [CNT_W-1:0]  stall_count
);

    // Tracked entries; index 1 is EX, index STAGES is the oldest.
    logic [STAGES:1]   ent_valid;
    logic [STAGES:1]   ent_wr;
    logic [ADDR_W-1:0] ent_dst [1:STAGES];
    // Only the EX entry's load flag is ever consulted: a load that has
    // reached MEM or later has its data and forwards normally.
    logic              ex_load;

    logic [STAGES:1]   match_a;
    logic [STAGES:1]   match_b;
    logic              issue;

    // An instruction enters EX only if it is real, not held and not killed.
    assign issue = id_valid && !stall && !ex_flush;

    // Per-stage producer match for each source operand.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 1; k <= STAGES; k++) begin
            match_a[k] = ent_valid[k] && ent_wr[k] && id_src_a_used
                         && (ent_dst[k] == id_src_a);
            match_b[k] = ent_valid[k] && ent_wr[k] && id_src_b_used
                         && (ent_dst[k] == id_src_b);
`ifdef HAZARD_R0_HARDWIRED_EN
            if (ent_dst[k] == '0) begin
                match_a[k] = 1'b0;
                match_b[k] = 1'b0;
            end
`endif
        end
    end

    // Forward from the youngest matching producer; scanning oldest-first
    // lets the lowest stage number overwrite any older match.
    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (match_a[k]) fwd_sel_a = SEL_W'(k);
            if (match_b[k]) fwd_sel_b = SEL_W'(k);
        end
    end

    // Load-use stall: a load in EX cannot forward to the ID instruction.
    // A taken branch/jump kills ID anyway, so flush suppresses the stall.
    always_comb begin
        stall = id_valid && !ex_flush && ex_load && ent_valid[1]
                && (match_a[1] || match_b[1]);
    end

    // Valid bits: load EX from ID (or a bubble), shift the rest down;
    // a flush turns the killed EX instruction into a bubble in MEM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_valid <= '0;
        end else begin
            ent_valid[1] <= issue;
            for (int k = 2; k <= STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1];
            end
            if (ex_flush) begin
                ent_valid[2] <= 1'b0;
            end
        end
    end

    // Entry payload shifts alongside the valid bits.
    // NOTE: the payload has no reset; it is only ever read qualified by
    // ent_valid, which is cleared, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        ent_dst[1] <= id_dst;
        ent_wr[1]  <= id_reg_write;
        ex_load    <= id_is_load;
        for (int k = 2; k <= STAGES; k++) begin
            ent_dst[k] <= ent_dst[k-1];
            ent_wr[k]  <= ent_wr[k-1];
        end
    end

    // Count stall cycles, holding at the all-ones maximum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Testbench for pipe_hazard_scoreboard: a table of per-cycle vectors with
// hand-computed expectations, followed by hand-written sequences for
// reset in mid-operation and counter saturation (second instance, CNT_W=2).
// Expectations for R0 follow HAZARD_R0_HARDWIRED_EN when it is defined.
module tb_pipe_hazard_scoreboard;

`ifdef HAZARD_R0_HARDWIRED_EN
    localparam bit R0_HW = 1'b1;
`else
    localparam bit R0_HW = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [2:0] id_src_a;
    logic       id_src_a_used;
    logic [2:0] id_src_b;
    logic       id_src_b_used;
    logic [2:0] id_dst;
    logic       id_reg_write;
    logic       id_is_load;
    logic       ex_flush;

    logic        stall;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [15:0] stall_count;

    logic        stall_s;
    logic [1:0]  fwd_sel_a_s;
    logic [1:0]  fwd_sel_b_s;
    logic [1:0]  stall_count_s;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_scoreboard u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_src_a(id_src_a), .id_src_a_used(id_src_a_used),
        .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_flush(ex_flush), .stall(stall), .fwd_sel_a(fwd_sel_a),
        .fwd_sel_b(fwd_sel_b), .stall_count(stall_count)
    );

    pipe_hazard_scoreboard #(.CNT_W(2)) u_dut_small (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_src_a(id_src_a), .id_src_a_used(id_src_a_used),
        .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_flush(ex_flush), .stall(stall_s), .fwd_sel_a(fwd_sel_a_s),
        .fwd_sel_b(fwd_sel_b_s), .stall_count(stall_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] sa;
        logic       ua;
        logic [2:0] sb;
        logic       ub;
        logic [2:0] dst;
        logic       wr;
        logic       ld;
        logic       fl;
        logic       e_stall;
        logic [1:0] e_fa;
        logic       ca;
        logic [1:0] e_fb;
        logic       cb;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [2:0] sa, logic ua,
                                logic [2:0] sb, logic ub, logic [2:0] dst,
                                logic wr, logic ld, logic fl,
                                logic e_stall, logic [1:0] e_fa, logic ca,
                                logic [1:0] e_fb, logic cb, int e_cnt);
        vec_t r;
        r.v = v; r.sa = sa; r.ua = ua; r.sb = sb; r.ub = ub;
        r.dst = dst; r.wr = wr; r.ld = ld; r.fl = fl;
        r.e_stall = e_stall; r.e_fa = e_fa; r.ca = ca;
        r.e_fb = e_fb; r.cb = cb; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] sa, input logic ua,
                         input logic [2:0] sb, input logic ub,
                         input logic [2:0] dst, input logic wr,
                         input logic ld, input logic fl);
        id_valid = v; id_src_a = sa; id_src_a_used = ua;
        id_src_b = sb; id_src_b_used = ub; id_dst = dst;
        id_reg_write = wr; id_is_load = ld; ex_flush = fl;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //          v sa ua sb ub dst wr ld fl | st fa ca fb cb cnt
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0)); // post-reset idle
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 1, 0, 1, 0)); // write R3
        vecs.push_back(mk(1, 3, 1, 3, 0, 7, 0, 0, 0,  0, 1, 1, 0, 1, 0)); // read R3 -> 1, B unused
        vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0,  0, 0, 1, 0, 1, 0)); // write R4
        vecs.push_back(mk(1, 3, 1, 4, 1, 6, 1, 0, 0,  0, 3, 1, 1, 1, 0)); // R3 -> 3, R4 -> 1
        vecs.push_back(mk(1, 4, 1, 6, 1, 7, 0, 0, 0,  0, 2, 1, 1, 1, 0)); // R4 -> 2
        vecs.push_back(mk(1, 4, 1, 3, 1, 7, 0, 0, 0,  0, 3, 1, 0, 1, 0)); // R4 -> 3, R3 retired
        vecs.push_back(mk(1, 4, 1, 6, 1, 7, 0, 0, 0,  0, 0, 1, 3, 1, 0)); // R4 retired
        vecs.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0, 1, 0, 1, 0)); // write R5
        vecs.push_back(mk(1, 5, 1, 0, 0, 5, 1, 0, 0,  0, 1, 1, 0, 1, 0)); // write R5 again
        vecs.push_back(mk(1, 5, 1, 5, 1, 7, 0, 0, 0,  0, 1, 1, 1, 1, 0)); // youngest wins
        vecs.push_back(mk(1, 0, 0, 5, 1, 7, 0, 0, 0,  0, 0, 1, 2, 1, 0)); // younger copy in MEM
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0,  0, 0, 1, 0, 1, 0)); // load R2
        vecs.push_back(mk(1, 0, 0, 2, 1, 7, 0, 0, 0,  1, 0, 1, 0, 0, 0)); // load-use stall
        vecs.push_back(mk(1, 0, 0, 2, 1, 7, 0, 0, 0,  0, 0, 1, 2, 1, 1)); // held instr -> 2
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 1)); // idle
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 1, 0, 1, 1)); // load R1
        vecs.push_back(mk(1, 1, 1, 0, 0, 7, 0, 0, 1,  0, 1, 1, 0, 1, 1)); // flush beats stall
        vecs.push_back(mk(1, 1, 1, 0, 0, 7, 0, 0, 0,  0, 0, 1, 0, 1, 1)); // killed load gone
        vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 1, 0,  0, 0, 1, 0, 1, 1)); // load R6
        vecs.push_back(mk(1, 0, 0, 0, 0, 7, 0, 0, 0,  0, 0, 1, 0, 1, 1)); // unrelated
        vecs.push_back(mk(1, 6, 1, 0, 0, 7, 0, 0, 0,  0, 2, 1, 0, 1, 1)); // load in MEM forwards
        vecs.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0,  0, 0, 1, 0, 1, 1)); // store-like, dst R3
        vecs.push_back(mk(1, 3, 1, 0, 0, 7, 0, 0, 0,  0, 0, 1, 0, 1, 1)); // no match without wr
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 1, 1)); // load R0
        vecs.push_back(mk(1, 0, 1, 0, 0, 7, 0, 0, 0,  R0_HW ? 1'b0 : 1'b1, 0, R0_HW, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 7, 0, 0, 0,  0, R0_HW ? 2'd0 : 2'd2, 1, 0, 1,
                          R0_HW ? 1 : 2));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].sa, vecs[i].ua, vecs[i].sb, vecs[i].ub,
                  vecs[i].dst, vecs[i].wr, vecs[i].ld, vecs[i].fl);
            #1;
            check($sformatf("vec%0d_stall", i), int'(stall), int'(vecs[i].e_stall));
            if (vecs[i].ca)
                check($sformatf("vec%0d_fwd_a", i), int'(fwd_sel_a), int'(vecs[i].e_fa));
            if (vecs[i].cb)
                check($sformatf("vec%0d_fwd_b", i), int'(fwd_sel_b), int'(vecs[i].e_fb));
            check($sformatf("vec%0d_count", i), int'(stall_count), vecs[i].e_cnt);
            check($sformatf("vec%0d_count_small", i), int'(stall_count_s),
                  (vecs[i].e_cnt > 3) ? 3 : vecs[i].e_cnt);
            @(negedge clk);
        end

        // Reset in mid-operation: a pending load R4 and the counter are dropped.
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 4, 1, 0, 0, 7, 0, 0, 0);
        #1;
        check("midreset_stall", int'(stall), 0);
        check("midreset_fwd_a", int'(fwd_sel_a), 0);
        check("midreset_count", int'(stall_count), 0);
        check("midreset_count_small", int'(stall_count_s), 0);
        @(negedge clk);

        // Five load-use pairs: the 2-bit counter must saturate at 3.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
            @(negedge clk);
            drive(1, 0, 0, 2, 1, 7, 0, 0, 0);
            #1;
            check($sformatf("sat%0d_stall", i), int'(stall), 1);
            @(negedge clk);
            #1;
            check($sformatf("sat%0d_unstall", i), int'(stall), 0);
            check($sformatf("sat%0d_fwd_b", i), int'(fwd_sel_b), 2);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("sat_count", int'(stall_count), 5);
        check("sat_count_small", int'(stall_count_s), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
